regfile_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_read_port.sv | 45 ++++
 rtl/regfile_mp.sv | 95 +++++++++
 tb/tb_regfile_mp.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and packed-bus lane helpers for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 64;
  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned NUM_WRITE      = 2;

  // Low bit index of lane 'lane' in a packed bus of 'width'-bit lanes.
  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: storage mux, zero-register check, write-lane bypass.
// Zero latency; no flow control.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned BYPASS     = 1,
  parameter int unsigned ZERO_REG   = 1
) (
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic [DATA_WIDTH-1:0]           regs [2**ADDR_WIDTH],
  input  logic [NUM_WRITE-1:0]            write_en,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] write_addr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0]           data
);

  logic                  hit;
  logic [DATA_WIDTH-1:0] byp_data;
  logic                  is_zero;

  // Ascending lane order lets the higher lane overwrite, so lane 1 wins.
  always_comb begin
    hit      = 1'b0;
    byp_data = '0;
    for (int i = 0; i < int'(NUM_WRITE); i++) begin
      if (write_en[i] && write_addr[lane_lo(i, ADDR_WIDTH) +: ADDR_WIDTH] == addr) begin
        hit      = 1'b1;
        byp_data = write_data[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  assign is_zero = (ZERO_REG != 0) && (addr == '0);

  always_comb begin
    data = regs[addr];
    if (is_zero)
      data = '0;
    else if ((BYPASS != 0) && hit)
      data = byp_data;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_READ combinational reads, two write lanes, busy scoreboard.
// Reads have zero latency (optional same-cycle bypass); no back-pressure.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned BYPASS     = 1,
  parameter int unsigned ZERO_REG   = 1
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic [NUM_WRITE-1:0]           write_En,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] writeAddr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] addr_rd,
  output logic [NUM_READ*DATA_WIDTH-1:0] data_out,
  input  logic                           busy_set_En,
  input  logic [ADDR_WIDTH-1:0]          busySetAddr,
  output logic [NUM_READ-1:0]            busy_out,
  output logic [2**ADDR_WIDTH-1:0]       busy_vec
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      busy_nxt;
  logic [DEPTH-1:0]      set_vec;
  logic [DEPTH-1:0]      clr_vec;
  logic [NUM_WRITE-1:0]  lane_we;

  // Writes aimed at the hardwired zero register never reach storage.
  always_comb begin
    for (int i = 0; i < int'(NUM_WRITE); i++) begin
      lane_we[i] = write_En[i] &&
                   !((ZERO_REG != 0) && (writeAddr[lane_lo(i, ADDR_WIDTH) +: ADDR_WIDTH] == '0));
    end
  end

  // A new producer issued in the same cycle the old one retires keeps the register busy.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (busy_set_En)
      set_vec[busySetAddr] = 1'b1;
    for (int i = 0; i < int'(NUM_WRITE); i++) begin
      if (write_En[i])
        clr_vec[writeAddr[lane_lo(i, ADDR_WIDTH) +: ADDR_WIDTH]] = 1'b1;
    end
    busy_nxt = (busy_q & ~clr_vec) | set_vec;
    if (ZERO_REG != 0)
      busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int r = 0; r < int'(DEPTH); r++)
        regs[r] <= '0;
      busy_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_WRITE); i++) begin
        if (lane_we[i])
          regs[writeAddr[lane_lo(i, ADDR_WIDTH) +: ADDR_WIDTH]] <=
            data_in[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH];
      end
      busy_q <= busy_nxt;
    end
  end

  assign busy_vec = busy_q;

  for (genvar p = 0; p < int'(NUM_READ); p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] rd_addr;
    assign rd_addr = addr_rd[lane_lo(p, ADDR_WIDTH) +: ADDR_WIDTH];

    regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .BYPASS     (BYPASS),
      .ZERO_REG   (ZERO_REG)
    ) u_port (
      .addr       (rd_addr),
      .regs       (regs),
      .write_en   (write_En),
      .write_addr (writeAddr),
      .write_data (data_in),
      .data       (data_out[lane_lo(p, DATA_WIDTH) +: DATA_WIDTH])
    );

    assign busy_out[p] = busy_q[rd_addr];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed vector bench: a bypassing 3-port instance and a non-bypassing 2-port
// instance share all write and scoreboard inputs.
module tb_regfile_mp;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [1:0]   write_En;
  logic [9:0]   writeAddr;
  logic [127:0] data_in;
  logic [14:0]  addr_rd;
  logic [191:0] data_out;
  logic         busy_set_En;
  logic [4:0]   busySetAddr;
  logic [2:0]   busy_out;
  logic [31:0]  busy_vec;

  logic [9:0]   nb_addr_rd;
  logic [127:0] nb_data_out;
  logic [1:0]   nb_busy_out;
  logic [31:0]  nb_busy_vec;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  regfile_mp #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .NUM_READ(3), .BYPASS(1), .ZERO_REG(1)) dut (
    .Clk(Clk), .Rst(Rst), .write_En(write_En), .writeAddr(writeAddr), .data_in(data_in),
    .addr_rd(addr_rd), .data_out(data_out), .busy_set_En(busy_set_En),
    .busySetAddr(busySetAddr), .busy_out(busy_out), .busy_vec(busy_vec)
  );

  regfile_mp #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .NUM_READ(2), .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .Clk(Clk), .Rst(Rst), .write_En(write_En), .writeAddr(writeAddr), .data_in(data_in),
    .addr_rd(nb_addr_rd), .data_out(nb_data_out), .busy_set_En(busy_set_En),
    .busySetAddr(busySetAddr), .busy_out(nb_busy_out), .busy_vec(nb_busy_vec)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [63:0] wd0, wd1;
    logic [4:0]  ra0, ra1, ra2;
    logic        bse;
    logic [4:0]  bsa;
    logic [63:0] e0, e1, e2;
    logic [2:0]  eb;
    logic [31:0] evec;
    logic [63:0] n0, n1;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int rst, input int we,
                              input int wa0, input bit [63:0] wd0,
                              input int wa1, input bit [63:0] wd1,
                              input int ra0, input int ra1, input int ra2,
                              input int bse, input int bsa,
                              input bit [63:0] e0, input bit [63:0] e1, input bit [63:0] e2,
                              input int eb, input bit [31:0] evec,
                              input bit [63:0] n0, input bit [63:0] n1);
    vec_t v;
    v.rst = 1'(rst);  v.we = 2'(we);
    v.wa0 = 5'(wa0);  v.wd0 = wd0;  v.wa1 = 5'(wa1);  v.wd1 = wd1;
    v.ra0 = 5'(ra0);  v.ra1 = 5'(ra1);  v.ra2 = 5'(ra2);
    v.bse = 1'(bse);  v.bsa = 5'(bsa);
    v.e0 = e0;  v.e1 = e1;  v.e2 = e2;  v.eb = 3'(eb);  v.evec = evec;
    v.n0 = n0;  v.n1 = n1;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    Rst         = v.rst;
    write_En    = v.we;
    writeAddr   = {v.wa1, v.wa0};
    data_in     = {v.wd1, v.wd0};
    addr_rd     = {v.ra2, v.ra1, v.ra0};
    nb_addr_rd  = {v.ra1, v.ra0};
    busy_set_En = v.bse;
    busySetAddr = v.bsa;
  endtask

  initial begin
    vec_t idle;
    // Each row: inputs for one cycle, outputs expected just before that cycle's edge.
    //   rst we wa0 wd0      wa1 wd1  ra0 ra1 ra2 bse bsa | e0 e1 e2 busy vec nb0 nb1
    add(0, 1,  5, 'hDEAD,   0, 0,    5,  7,  0,  0, 0,   'hDEAD, 0, 0, 0, 0, 0, 0);
    add(1, 2,  0, 0,        7, 'h77, 5,  7,  0,  0, 0,   'hDEAD, 'h77, 0, 0, 0, 'hDEAD, 0);
    add(0, 2,  0, 0,        3, 'h33, 5,  7,  0,  0, 0,   0, 0, 0, 0, 0, 0, 0);
    add(0, 1,  0, 'hFFFF,   0, 0,    0,  3,  0,  0, 0,   0, 'h33, 0, 0, 0, 0, 'h33);
    add(0, 3,  9, 'h11,     9, 'h22, 0,  9,  9,  0, 0,   0, 'h22, 'h22, 0, 0, 0, 0);
    add(0, 1,  4, 'h1234,   0, 0,    9,  4,  0,  1, 12,  'h22, 'h1234, 0, 0, 0, 'h22, 0);
    add(0, 1, 12, 'hAB,     0, 0,    4, 12, 12,  1, 12,  'h1234, 'hAB, 'hAB, 'b110, 'h1000, 'h1234, 0);
    add(0, 2,  0, 0,       12, 'hCD, 12, 12,  4,  0, 0,   'hCD, 'hCD, 'h1234, 'b011, 'h1000, 'hAB, 'hAB);
    add(0, 2,  0, 0,        2, 'h55, 12,  2,  2,  0, 0,   'hCD, 'h55, 'h55, 0, 0, 'hCD, 0);
    add(0, 0,  0, 0,        0, 0,    0,  2,  2,  1, 0,   0, 'h55, 'h55, 0, 0, 0, 'h55);
    add(0, 1, 31, 'hF0,     0, 0,    0,  3,  3,  1, 31,  0, 'h33, 'h33, 0, 0, 0, 'h33);
    add(0, 1,  7, 'h70,     0, 0,   31, 31,  0,  0, 0,   'hF0, 'hF0, 0, 'b011, 'h8000_0000, 'hF0, 'hF0);
    add(0, 1, 31, 'hFEDC_BA98_7654_3210, 0, 0, 7, 31, 0, 0, 0,
        'h70, 'hFEDC_BA98_7654_3210, 0, 'b010, 'h8000_0000, 'h70, 'hF0);
    add(0, 0,  0, 0,        0, 0,   31,  7,  0,  0, 0,
        'hFEDC_BA98_7654_3210, 'h70, 0, 0, 0, 'hFEDC_BA98_7654_3210, 'h70);

    idle = '{rst: 1'b1, we: 2'b00, wa0: 5'd0, wa1: 5'd0, wd0: 64'd0, wd1: 64'd0,
             ra0: 5'd0, ra1: 5'd0, ra2: 5'd0, bse: 1'b0, bsa: 5'd0,
             e0: 64'd0, e1: 64'd0, e2: 64'd0, eb: 3'd0, evec: 32'd0, n0: 64'd0, n1: 64'd0};
    drive(idle);
    @(posedge Clk);
    @(posedge Clk);

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge Clk);
      drive(tbl[k]);
      #1;
      chk($sformatf("v%0d d0", k),      data_out[63:0],    tbl[k].e0);
      chk($sformatf("v%0d d1", k),      data_out[127:64],  tbl[k].e1);
      chk($sformatf("v%0d d2", k),      data_out[191:128], tbl[k].e2);
      chk($sformatf("v%0d busy_out", k), 64'(busy_out),    64'(tbl[k].eb));
      chk($sformatf("v%0d busy_vec", k), 64'(busy_vec),    64'(tbl[k].evec));
      chk($sformatf("v%0d nb d0", k),   nb_data_out[63:0],   tbl[k].n0);
      chk($sformatf("v%0d nb d1", k),   nb_data_out[127:64], tbl[k].n1);
      chk($sformatf("v%0d nb busy_vec", k), 64'(nb_busy_vec), 64'(tbl[k].evec));
      chk($sformatf("v%0d nb busy_out", k), 64'(nb_busy_out), 64'(tbl[k].eb[1:0]));
    end

    // Reset clears a pending busy bit and ignores a same-cycle busy_set and write.
    @(negedge Clk);
    idle.rst = 1'b0;
    drive(idle);
    busy_set_En = 1'b1;
    busySetAddr = 5'd5;
    #1;
    chk("seq busy before set", 64'(busy_vec), 64'd0);

    @(negedge Clk);
    idle.rst = 1'b1;
    idle.we  = 2'b01;
    idle.wa0 = 5'd6;
    idle.wd0 = 64'h66;
    idle.ra0 = 5'd6;
    drive(idle);
    busy_set_En = 1'b1;
    busySetAddr = 5'd6;
    #1;
    chk("seq busy r5 set", 64'(busy_vec), 64'h20);
    chk("seq bypass in reset", data_out[63:0], 64'h66);
    chk("seq nb no bypass", nb_data_out[63:0], 64'd0);

    @(negedge Clk);
    idle.rst = 1'b0;
    idle.we  = 2'b00;
    idle.ra0 = 5'd6;
    idle.ra1 = 5'd5;
    idle.ra2 = 5'd31;
    drive(idle);
    #1;
    chk("seq post-reset busy_vec", 64'(busy_vec), 64'd0);
    chk("seq post-reset busy_out", 64'(busy_out), 64'd0);
    chk("seq post-reset r6", data_out[63:0], 64'd0);
    chk("seq post-reset r31", data_out[191:128], 64'd0);
    chk("seq post-reset nb r6", nb_data_out[63:0], 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
